// File: rtl/jt89_wrseq.sv
// Command-level writer for the jt89 PSG bus: a command FIFO plus an encoder
// that turns each command into one or two strobed PSG bytes.
//
// state   | meaning
// IDLE    | nothing in flight; pops the FIFO when psg_ready is high
// STROBE  | psg_wr_n/psg_ce_n held low for WR_LEN cycles
// RECOVER | GAP-cycle holdoff, then waits on psg_ready for the next byte
module jt89_wrseq #(
  parameter int DEPTH  = 4,
  parameter int WR_LEN = 2,
  parameter int GAP    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [1:0] cmd_ch,
  input  logic [9:0] cmd_data,
  input  logic       psg_ready,
  output logic       psg_wr_n,
  output logic       psg_ce_n,
  output logic [7:0] psg_din,
  output logic       busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_MAX = (WR_LEN > GAP) ? WR_LEN : GAP;
  localparam int CW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RECOVER
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            pend;
  logic [7:0]      pend_byte;

  logic [13:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            can_pop;

  logic [13:0]     head;
  logic [1:0]      h_type;
  logic [1:0]      h_ch;
  logic [9:0]      h_data;
  logic [7:0]      first_byte;
  logic [7:0]      second_byte;
  logic            two_bytes;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign can_pop   = (state == IDLE) || (state == RECOVER && cnt == '0 && !pend);
  assign pop       = can_pop && !empty && psg_ready;

  assign psg_ce_n  = psg_wr_n;
  assign busy      = !empty || (state != IDLE) || pend;

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {cmd_type, cmd_ch, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head   = mem[rd_ptr];
  assign h_type = head[13:12];
  assign h_ch   = head[11:10];
  assign h_data = head[9:0];

  // A tone on channel 3 is really the noise control register.
  always_comb begin
    first_byte  = 8'h00;
    second_byte = 8'h00;
    two_bytes   = 1'b0;
    case (h_type)
      2'd0: begin
        if (h_ch != 2'd3) begin
          first_byte  = {1'b1, h_ch, 1'b0, h_data[3:0]};
          second_byte = {2'b00, h_data[9:4]};
          two_bytes   = 1'b1;
        end else begin
          first_byte  = {5'b11100, h_data[2:0]};
        end
      end
      2'd1:    first_byte = {1'b1, h_ch, 1'b1, h_data[3:0]};
      2'd2:    first_byte = {5'b11100, h_data[2:0]};
      default: first_byte = h_data[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_byte <= 8'h00;
      psg_wr_n  <= 1'b1;
      psg_din   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            psg_din   <= first_byte;
            pend      <= two_bytes;
            pend_byte <= second_byte;
            cnt       <= CW'(WR_LEN);
            state     <= STROBE;
          end
        end
        STROBE: begin
          if (cnt != '0) begin
            psg_wr_n <= 1'b0;
            cnt      <= cnt - 1'b1;
          end else begin
            psg_wr_n <= 1'b1;
            cnt      <= CW'(GAP - 1);
            state    <= RECOVER;
          end
        end
        RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (psg_ready) begin
            if (pend) begin
              psg_din <= pend_byte;
              pend    <= 1'b0;
              cnt     <= CW'(WR_LEN);
              state   <= STROBE;
            end else if (pop) begin
              psg_din   <= first_byte;
              pend      <= two_bytes;
              pend_byte <= second_byte;
              cnt       <= CW'(WR_LEN);
              state     <= STROBE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt89_wrseq.sv
// Scoreboard bench for jt89_wrseq: expected PSG bytes are queued as commands
// are driven and matched as each strobe is observed on the bus.
module tb_jt89_wrseq;

  localparam int DEPTH  = 4;
  localparam int WR_LEN = 2;
  localparam int GAP    = 4;
  localparam int MIN_SPACING = 1 + WR_LEN + GAP;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [1:0] cmd_ch;
  logic [9:0] cmd_data;
  logic       psg_ready;
  logic       psg_wr_n;
  logic       psg_ce_n;
  logic [7:0] psg_din;
  logic       busy;

  jt89_wrseq #(.DEPTH(DEPTH), .WR_LEN(WR_LEN), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_ch    (cmd_ch),
    .cmd_data  (cmd_data),
    .psg_ready (psg_ready),
    .psg_wr_n  (psg_wr_n),
    .psg_ce_n  (psg_ce_n),
    .psg_din   (psg_din),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nstb  = 0;
  logic [7:0] exp_q[$];

  // PSG side: ready can be forced low, or follow a jt89-like busy window.
  logic ready_force_low = 1'b0;
  logic model_en        = 1'b0;
  int   busy_cnt        = 0;
  assign psg_ready = !ready_force_low && !(model_en && busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!psg_wr_n)         busy_cnt <= 32;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  logic [9:0] tone_r [4];
  logic [3:0] vol_r  [4];
  logic [2:0] latch_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus monitor: one sample per cycle, 1 time unit after the active edge.
  logic       prev_wr   = 1'b1;
  int         lowlen    = 0;
  logic [7:0] cur_byte  = 8'h00;
  logic       stable    = 1'b1;
  int         last_fall = -1;

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      prev_wr = 1'b1;
      lowlen  = 0;
    end else if (prev_wr && !psg_wr_n) begin
      nstb++;
      cur_byte = psg_din;
      stable   = 1'b1;
      lowlen   = 1;
      chk("ce_n_low", psg_ce_n, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", exp_q.size(), 1);
      end else begin
        chk("byte", psg_din, exp_q.pop_front());
      end
      if (last_fall >= 0) chk("spacing_ok", (cyc - last_fall) >= MIN_SPACING, 1'b1);
      last_fall = cyc;
      if (psg_din[7]) begin
        latch_r = psg_din[6:4];
        if (psg_din[4]) vol_r[psg_din[6:5]] = psg_din[3:0];
        else            tone_r[psg_din[6:5]][3:0] = psg_din[3:0];
      end else begin
        tone_r[latch_r[2:1]][9:4] = psg_din[5:0];
      end
      prev_wr = 1'b0;
    end else if (!prev_wr && !psg_wr_n) begin
      lowlen++;
      if (psg_din !== cur_byte) stable = 1'b0;
    end else if (!prev_wr && psg_wr_n) begin
      chk("strobe_len", lowlen, WR_LEN);
      chk("din_hold", stable && (psg_din === cur_byte), 1'b1);
      chk("ce_n_high", psg_ce_n, 1'b1);
      prev_wr = 1'b1;
    end
  end

  task automatic send(input logic [1:0] t, input logic [1:0] c, input logic [9:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_ch    = c;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1'b1);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(posedge clk);
    #1;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 2'd0;
    cmd_ch    = 2'd0;
    cmd_data  = 10'd0;
    for (int i = 0; i < 4; i++) begin
      tone_r[i] = 10'h3FF;
      vol_r[i]  = 4'hF;
    end
    latch_r = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wr_n", psg_wr_n, 1'b1);
    chk("rst_ce_n", psg_ce_n, 1'b1);
    chk("rst_din", psg_din, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);

    // Tone ch1 0x2A5 with exact first-byte latency.
    n0 = nstb;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h2A);
    send(2'd0, 2'd1, 10'h2A5);
    @(posedge clk); #1;
    chk("t1_din_e1", psg_din, 8'hA5);
    chk("t1_wr_n_e1", psg_wr_n, 1'b1);
    @(posedge clk); #1;
    chk("t1_wr_n_e2", psg_wr_n, 1'b0);
    repeat (WR_LEN - 1) @(posedge clk);
    #1;
    chk("t1_wr_n_last_low", psg_wr_n, 1'b0);
    @(posedge clk); #1;
    chk("t1_wr_n_release", psg_wr_n, 1'b1);
    wait_idle(200);
    chk("t1_strobes", nstb - n0, 2);
    chk("t1_busy", busy, 1'b0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Volume, noise, raw back-to-back.
    n0 = nstb;
    exp_q.push_back(8'hDF);
    exp_q.push_back(8'hE5);
    exp_q.push_back(8'h3C);
    send(2'd1, 2'd2, 10'h00F);
    send(2'd2, 2'd1, 10'h005);
    send(2'd3, 2'd3, 10'h03C);
    wait_idle(300);
    chk("t2_strobes", nstb - n0, 3);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Tone on channel 3 collapses to one noise byte.
    n0 = nstb;
    exp_q.push_back(8'hE6);
    send(2'd0, 2'd3, 10'h006);
    wait_idle(200);
    chk("t3_strobes", nstb - n0, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Against a jt89-like ready window.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tone_r[i] = 10'h3FF;
      vol_r[i]  = 4'hF;
    end
    model_en = 1'b1;
    n0 = nstb;
    exp_q.push_back(8'h8E);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h90);
    send(2'd0, 2'd0, 10'h0FE);
    send(2'd1, 2'd0, 10'h000);
    wait_idle(1000);
    chk("t4_tone0", tone_r[0], 10'h0FE);
    chk("t4_vol0", vol_r[0], 4'h0);
    chk("t4_strobes", nstb - n0, 3);
    chk("t4_sb_empty", exp_q.size(), 0);
    model_en = 1'b0;
    @(negedge clk);

    // Fill the FIFO with psg_ready held low, then drain.
    ready_force_low = 1'b1;
    n0 = nstb;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h40 + 8'(i * 7));
      send(2'd3, 2'd0, 10'h040 + 10'(i * 7));
    end
    chk("t5_full_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_type  = 2'd3;
    cmd_ch    = 2'd0;
    cmd_data  = 10'h055;
    repeat (4) @(negedge clk);
    chk("t5_still_full", cmd_ready, 1'b0);
    chk("t5_no_strobes", nstb - n0, 0);
    chk("t5_busy_full", busy, 1'b1);
    ready_force_low = 1'b0;
    @(posedge clk); #1;
    chk("t5_ready_back", cmd_ready, 1'b1);
    exp_q.push_back(8'h55);
    send(2'd3, 2'd0, 10'h055);
    exp_q.push_back(8'h66);
    send(2'd3, 2'd0, 10'h066);
    wait_idle(500);
    chk("t5_strobes", nstb - n0, DEPTH + 2);
    chk("t5_sb_empty", exp_q.size(), 0);
    @(negedge clk);

    // Reset in the middle of a tone's first strobe.
    n0 = nstb;
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h12);
    send(2'd0, 2'd0, 10'h123);
    begin
      int n = 0;
      while (psg_wr_n && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("t6_strobe_seen", psg_wr_n, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_type  = 2'd3;
    cmd_data  = 10'h077;
    @(posedge clk); #1;
    chk("t6_wr_n", psg_wr_n, 1'b1);
    chk("t6_ce_n", psg_ce_n, 1'b1);
    chk("t6_din", psg_din, 8'h00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    chk("t6_byte_b_dropped", exp_q.size(), 1);
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("t6_one_strobe", nstb - n0, 1);
    chk("t6_busy_after", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
